pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the single-cycle RISC-V core; sits directly upstream of the control unit.
- Holds the PC, fetches each instruction over a req/ready handshake to instruction memory, and presents it to decode.
- Consumes the control unit's Branch, JalFunct and PCMux, plus the ALU zero flag, to select the next PC.
- Stalls while a load/store owns the shared memory port, i.e. while HADDR_Sel is active.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- Branch  in  1  conditional branch, from control unit.
- Zero  in  1  ALU zero flag; branch is taken when Branch & Zero.
- JalFunct  in  1  JAL, from control unit.
- PCMux  in  1  JALR, from control unit.
- imm  in  XLEN  sign-extended immediate from the immediate generator.
- rs1_val  in  XLEN  register-file RD1.
- exec_hold  in  1  data access in progress (HADDR_Sel & bus busy); holds the current instruction.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address.
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- pc  out  XLEN  PC of the current instruction.
- pc_plus4  out  XLEN  pc+4, used as the JAL/JALR link value.
- instr  out  32  instruction register.
- instr_valid  out  1  instr is valid for decode/execute.
- instret  out  32  retired-instruction counter.

Behaviour:
- Reset (rst=1 at a clk edge, in any state, including mid-fetch):
  - State becomes IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instret=0.
  - imem_req=0 and instr_valid=0 from the next cycle.
  - An imem_ready arriving in the reset cycle is ignored.
- FSM states: IDLE, FETCH, EXEC.
- IDLE: exactly one cycle; imem_req=0; then go to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ready.
  - On imem_ready: instr<=imem_rdata, go to EXEC.
  - Minimum fetch latency is 1 cycle (ready in the same cycle as req); no upper bound, so FETCH waits indefinitely.
- EXEC:
  - instr_valid=1 and imem_req=0.
  - While exec_hold=1: remain in EXEC; pc, instr and instret are unchanged.
  - First cycle with exec_hold=0: pc<=next_pc, instret<=instret+1 (wraps 32'hFFFF_FFFF->0), go to FETCH.
  - A single-cycle instruction therefore costs fetch latency + 1 cycle.
- next_pc, combinational, evaluated in the EXEC exit cycle, in priority order:
  1. PCMux=1: (rs1_val+imm) & ~1.
  2. else JalFunct=1: pc+imm.
  3. else Branch & Zero: pc+imm.
  4. else pc+4.
- Simultaneous PCMux and JalFunct: PCMux wins.
- All additions are modulo 2^XLEN with no overflow detection.
- pc_plus4 = pc+4, combinational and valid in every state.
- instr_valid is registered and equals (state==EXEC).
- Control inputs are ignored outside EXEC.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Extra output misalign_trap (1 bit, reset 0).
  - If next_pc[1:0]!=0 at EXEC exit: pc is not updated, misalign_trap<=1 (sticky until rst), state moves to a HALT state with imem_req=0 and instr_valid=0, and instret still increments.
- Not defined:
  - No port and no HALT state.
  - next_pc[1:0] is forced to 0 before being loaded into pc.

Decomposition:
- Shared package rv_core_pkg: state encoding (IDLE=2'd0, FETCH=2'd1, EXEC=2'd2, HALT=2'd3), NOP_INSTR=32'h0000_0013, RESET_PC default.
- One natural sub-module, next_pc_sel: purely combinational priority mux and adders.
- The FSM, PC register and counter stay in pc_fetch_unit.

Test Plan:
- Reset then imem_ready=1 with rdata=32'h0050_0093 → IDLE 1 cycle, imem_addr=32'h0040_0000, then instr_valid=1 with instr=32'h0050_0093; next fetch at 32'h0040_0004; instret=1.
- Branch=1, Zero=1, imm=-8 at pc=32'h0040_0010 → next imem_addr=32'h0040_0008. With Zero=0 → next imem_addr=32'h0040_0014.
- PCMux=1, JalFunct=1, rs1_val=32'h0040_0101, imm=4 → next imem_addr=32'h0040_0104 (JALR wins, bit0 cleared); pc_plus4 was pc+4 during EXEC.
- imem_ready delayed 5 cycles, then exec_hold=1 for 3 cycles → imem_req/imem_addr stable for 5 cycles; instr_valid high 4 cycles; instret increments once.
- rst asserted during FETCH with imem_ready=1 in the same cycle → instr stays NOP, pc=RESET_PC, instret=0, IDLE.
- PC_MISALIGN_TRAP_EN: JalFunct=1, imm=2 → misalign_trap=1, imem_req stays 0, pc unchanged. Without the macro → next fetch at pc (bits [1:0] cleared).

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared types and constants for the PC/fetch stage of the single-cycle RISC-V core.
package rv_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic branch;
        logic zero;
        logic jal;
        logic jalr;
    } pc_ctrl_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Next-PC priority mux: JALR, then JAL, then taken branch, then sequential.
module next_pc_sel
    import rv_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  pc_ctrl_t        ctrl,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4
);

    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] pc_rel;

    assign pc_plus4 = pc + XLEN'(4);
    assign pc_rel   = pc + imm;
    assign jalr_sum = rs1_val + imm;

    always_comb begin
        next_pc = pc_plus4;
        if (ctrl.jalr)
            next_pc = {jalr_sum[XLEN-1:1], 1'b0};
        else if (ctrl.jal)
            next_pc = pc_rel;
        else if (ctrl.branch && ctrl.zero)
            next_pc = pc_rel;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch handshake FSM and retired-instruction counter.
// Optional misaligned-target trap with HALT state under PC_MISALIGN_TRAP_EN.
module pc_fetch_unit
    import rv_core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Branch,
    input  logic            Zero,
    input  logic            JalFunct,
    input  logic            PCMux,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            exec_hold,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [31:0]     instret
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic            misalign_trap
`endif
);

    fetch_state_t    state;
    pc_ctrl_t        ctrl;
    logic [XLEN-1:0] next_pc;

    assign ctrl = '{branch: Branch, zero: Zero, jal: JalFunct, jalr: PCMux};

    next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
        .ctrl     (ctrl),
        .pc       (pc),
        .imm      (imm),
        .rs1_val  (rs1_val),
        .next_pc  (next_pc),
        .pc_plus4 (pc_plus4)
    );

    // pc only changes on EXEC exit, so the address is stable for the whole fetch
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            instr         <= NOP_INSTR;
            instret       <= '0;
            imem_req      <= 1'b0;
            instr_valid   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_trap <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        state       <= ST_EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!exec_hold) begin
                        instret     <= instret + 32'd1;
                        instr_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
                        if (next_pc[1:0] != 2'b00) begin
                            misalign_trap <= 1'b1;
                            state         <= ST_HALT;
                        end else begin
                            pc       <= next_pc;
                            state    <= ST_FETCH;
                            imem_req <= 1'b1;
                        end
`else
                        pc       <= next_pc & ~XLEN'(3);
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
`endif
                    end
                end
`ifdef PC_MISALIGN_TRAP_EN
                ST_HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
`endif
                default: begin
                    state       <= ST_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
